// File: rtl/tri_setup_pkg.sv
// ----------------------------------------------------------------
// tri_setup_pkg: shared types, encodings and width helpers for triangle setup
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package tri_setup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DIV   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [1:0] CULL_NONE = 2'd0;
  localparam logic [1:0] CULL_NEG  = 2'd1;
  localparam logic [1:0] CULL_POS  = 2'd2;

  localparam int SUBPIX_FRAC = 8;

  function automatic int num_w(input int aw, input int iw);
    return aw + iw + 11;
  endfunction

  function automatic int const_w(input int iw);
    return 2 * iw + 1;
  endfunction

  function automatic int area_w(input int iw);
    return 2 * iw + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tri_setup_multi_seq_sdiv.sv
// ----------------------------------------------------------------
// seq_sdiv: signed restoring divider, one quotient bit per clock, AW-bit saturated result
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module seq_sdiv #(
  parameter int NW = 67,
  parameter int DW = 50,
  parameter int AW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic signed [NW-1:0] i_num,
  input  logic signed [DW-1:0] i_den,
  output logic                 o_done,
  output logic [AW-1:0]        o_quo
);

  localparam int CNT_W = $clog2(NW + 1);

  logic [DW-1:0]    r_rem;
  logic [NW-1:0]    r_quo;
  logic [DW-1:0]    r_den;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_fin;

  logic [NW-1:0] w_num_mag;
  logic [DW-1:0] w_den_mag;
  logic [DW-1:0] w_rem_in;
  logic [NW-1:0] w_quo_in;
  logic [DW-1:0] w_den_in;
  logic [DW:0]   w_sh;
  logic          w_ge;
  logic [DW-1:0] w_rem_nx;
  logic [NW-1:0] w_quo_nx;
  logic          w_hi;
  logic [AW-1:0] w_lo;
  logic [AW-1:0] w_lo_neg;

  assign w_num_mag = i_num[NW-1] ? -i_num : i_num;
  assign w_den_mag = i_den[DW-1] ? -i_den : i_den;

  // The load cycle already performs the first iteration, so a divide spans NW+1 cycles.
  always_comb begin
    w_rem_in = i_start ? '0 : r_rem;
    w_quo_in = i_start ? w_num_mag : r_quo;
    w_den_in = i_start ? w_den_mag : r_den;
    w_sh     = {w_rem_in, w_quo_in[NW-1]};
    w_ge     = (w_sh >= {1'b0, w_den_in});
    w_rem_nx = w_ge ? DW'(w_sh - {1'b0, w_den_in}) : w_sh[DW-1:0];
    w_quo_nx = {w_quo_in[NW-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_fin  <= 1'b0;
    end else if (i_start) begin
      r_rem  <= w_rem_nx;
      r_quo  <= w_quo_nx;
      r_den  <= w_den_mag;
      r_neg  <= i_num[NW-1] ^ i_den[DW-1];
      r_cnt  <= CNT_W'(NW - 1);
      r_busy <= 1'b1;
      r_fin  <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_fin  <= 1'b1;
      end
    end else begin
      r_fin <= 1'b0;
    end
  end

  assign w_hi     = |r_quo[NW-1:AW-1];
  assign w_lo     = r_quo[AW-1:0];
  assign w_lo_neg = -w_lo;
  assign o_done   = r_fin;
  assign o_quo    = r_neg ? (w_hi ? {1'b1, {(AW-1){1'b0}}} : w_lo_neg)
                          : (w_hi ? {1'b0, {(AW-1){1'b1}}} : w_lo);

endmodule

`default_nettype wire

// File: rtl/tri_setup_multi.sv
// ----------------------------------------------------------------
// tri_setup_multi: edge/area setup, culling and multi-attribute gradients
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tri_setup_multi
  import tri_setup_pkg::*;
#(
  parameter int IW    = 24,
  parameter int AW    = 32,
  parameter int NATTR = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IW-1:0]         x0, y0, x1, y1, x2, y2,
  input  logic [NATTR*AW-1:0]   a0, a1, a2,
  input  logic [1:0]            cull_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IW:0]           A0, A1, A2, B0, B1, B2,
  output logic [2*IW:0]         C0, C1, C2,
  output logic [2*IW+1:0]       area,
  output logic                  back_facing,
  output logic [NATTR*AW-1:0]   grad_x, grad_y,
  output logic                  cull_evt,
  output logic [15:0]           cull_count
);

  localparam int EDGE_W  = IW + 1;
  localparam int CONST_W = const_w(IW);
  localparam int AREA_W  = area_w(IW);
  localparam int NUM_W   = num_w(AW, IW);
  localparam int KW      = (NATTR > 1) ? $clog2(NATTR) : 1;

  state_t r_state, w_state_nx;
  logic signed [IW-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic [NATTR*AW-1:0]  r_a0, r_a1, r_a2, r_gx, r_gy;
  logic [1:0]           r_mode;
  logic [KW-1:0]        r_k;
  logic                 r_axis, r_pend, r_bf, r_cull_evt;
  logic [EDGE_W-1:0]    r_A0, r_A1, r_A2, r_B0, r_B1, r_B2;
  logic [CONST_W-1:0]   r_C0, r_C1, r_C2;
  logic [AREA_W-1:0]    r_area;
  logic [15:0]          r_cull_cnt;

  logic signed [EDGE_W-1:0]  w_dx1, w_dy1, w_dx2, w_dy2;
  logic signed [EDGE_W-1:0]  w_a0e, w_a1e, w_a2e, w_b0e, w_b1e, w_b2e;
  logic signed [CONST_W-1:0] w_c0e, w_c1e, w_c2e;
  logic signed [AREA_W-1:0]  w_d;
  logic signed [AW-1:0]      w_a0k, w_a1k, w_a2k;
  logic signed [AW:0]        w_da1, w_da2;
  logic signed [NUM_W-1:0]   w_nx, w_ny, w_num;
  logic [AW-1:0]             w_quo;
  logic w_cull_hit, w_cull, w_flip, w_last, w_div_start, w_div_done;

  assign w_dx1 = EDGE_W'(r_x1) - EDGE_W'(r_x0);
  assign w_dy1 = EDGE_W'(r_y1) - EDGE_W'(r_y0);
  assign w_dx2 = EDGE_W'(r_x2) - EDGE_W'(r_x0);
  assign w_dy2 = EDGE_W'(r_y2) - EDGE_W'(r_y0);

  assign w_a0e = EDGE_W'(r_y1) - EDGE_W'(r_y2);
  assign w_b0e = EDGE_W'(r_x2) - EDGE_W'(r_x1);
  assign w_c0e = CONST_W'(r_x1) * CONST_W'(r_y2) - CONST_W'(r_x2) * CONST_W'(r_y1);
  assign w_a1e = EDGE_W'(r_y2) - EDGE_W'(r_y0);
  assign w_b1e = EDGE_W'(r_x0) - EDGE_W'(r_x2);
  assign w_c1e = CONST_W'(r_x2) * CONST_W'(r_y0) - CONST_W'(r_x0) * CONST_W'(r_y2);
  assign w_a2e = EDGE_W'(r_y0) - EDGE_W'(r_y1);
  assign w_b2e = EDGE_W'(r_x1) - EDGE_W'(r_x0);
  assign w_c2e = CONST_W'(r_x0) * CONST_W'(r_y1) - CONST_W'(r_x1) * CONST_W'(r_y0);

  assign w_d = AREA_W'(w_dx1) * AREA_W'(w_dy2) - AREA_W'(w_dx2) * AREA_W'(w_dy1);

  assign w_flip     = (w_d < 0);
  assign w_cull_hit = (w_d == 0) || ((r_mode == CULL_NEG) && (w_d < 0))
                                  || ((r_mode == CULL_POS) && (w_d > 0));

  // Latched coordinates stay stable through DIV, so numerators and D are recomputed per divide.
  assign w_a0k = r_a0[r_k*AW +: AW];
  assign w_a1k = r_a1[r_k*AW +: AW];
  assign w_a2k = r_a2[r_k*AW +: AW];
  assign w_da1 = (AW+1)'(w_a1k) - (AW+1)'(w_a0k);
  assign w_da2 = (AW+1)'(w_a2k) - (AW+1)'(w_a0k);
  assign w_nx  = NUM_W'(w_da1) * NUM_W'(w_dy2) - NUM_W'(w_da2) * NUM_W'(w_dy1);
  assign w_ny  = NUM_W'(w_da2) * NUM_W'(w_dx1) - NUM_W'(w_da1) * NUM_W'(w_dx2);
  assign w_num = (r_axis ? w_ny : w_nx) <<< SUBPIX_FRAC;

  assign w_last      = (r_k == KW'(NATTR - 1)) && r_axis;
  assign w_div_start = (r_state == ST_DIV) && r_pend;

  seq_sdiv #(.NW(NUM_W), .DW(AREA_W), .AW(AW)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   (w_d),
    .o_done  (w_div_done),
    .o_quo   (w_quo)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cull     = 1'b0;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nx = ST_SETUP;
      ST_SETUP: begin
        if (w_cull_hit) begin
          w_cull     = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_DIV;
        end
      end
      ST_DIV:   if (w_div_done && w_last) w_state_nx = ST_OUT;
      ST_OUT:   if (out_ready) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      {r_x0, r_y0, r_x1, r_y1, r_x2, r_y2} <= '0;
      {r_a0, r_a1, r_a2, r_gx, r_gy} <= '0;
      r_mode <= CULL_NONE;
      r_k <= '0;
      {r_axis, r_pend, r_bf, r_cull_evt} <= '0;
      {r_A0, r_A1, r_A2, r_B0, r_B1, r_B2} <= '0;
      {r_C0, r_C1, r_C2} <= '0;
      r_area <= '0;
      r_cull_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cull_evt <= w_cull;
      if (w_cull && (r_cull_cnt != 16'hFFFF)) r_cull_cnt <= r_cull_cnt + 16'd1;
      if ((r_state == ST_IDLE) && in_valid) begin
        {r_x0, r_y0, r_x1, r_y1, r_x2, r_y2} <= {x0, y0, x1, y1, x2, y2};
        {r_a0, r_a1, r_a2} <= {a0, a1, a2};
        r_mode <= cull_mode;
      end
      if (r_state == ST_SETUP) begin
        r_A0   <= w_flip ? -w_a0e : w_a0e;
        r_A1   <= w_flip ? -w_a1e : w_a1e;
        r_A2   <= w_flip ? -w_a2e : w_a2e;
        r_B0   <= w_flip ? -w_b0e : w_b0e;
        r_B1   <= w_flip ? -w_b1e : w_b1e;
        r_B2   <= w_flip ? -w_b2e : w_b2e;
        r_C0   <= w_flip ? -w_c0e : w_c0e;
        r_C1   <= w_flip ? -w_c1e : w_c1e;
        r_C2   <= w_flip ? -w_c2e : w_c2e;
        r_area <= w_flip ? -w_d : w_d;
        r_bf   <= w_flip;
        r_k    <= '0;
        r_axis <= 1'b0;
        r_pend <= 1'b1;
      end
      if (w_div_start) r_pend <= 1'b0;
      if ((r_state == ST_DIV) && w_div_done) begin
        if (r_axis) r_gy[r_k*AW +: AW] <= w_quo;
        else        r_gx[r_k*AW +: AW] <= w_quo;
        if (!w_last) begin
          r_axis <= ~r_axis;
          if (r_axis) r_k <= r_k + KW'(1);
          r_pend <= 1'b1;
        end
      end
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_OUT);
  assign cull_evt    = r_cull_evt;
  assign cull_count  = r_cull_cnt;
  assign A0          = out_valid ? r_A0 : '0;
  assign A1          = out_valid ? r_A1 : '0;
  assign A2          = out_valid ? r_A2 : '0;
  assign B0          = out_valid ? r_B0 : '0;
  assign B1          = out_valid ? r_B1 : '0;
  assign B2          = out_valid ? r_B2 : '0;
  assign C0          = out_valid ? r_C0 : '0;
  assign C1          = out_valid ? r_C1 : '0;
  assign C2          = out_valid ? r_C2 : '0;
  assign area        = out_valid ? r_area : '0;
  assign back_facing = out_valid & r_bf;
  assign grad_x      = out_valid ? r_gx : '0;
  assign grad_y      = out_valid ? r_gy : '0;

endmodule

`default_nettype wire

// File: tb/tb_tri_setup_multi.sv
// ----------------------------------------------------------------
// tb_tri_setup_multi: directed vectors for tri_setup_multi (IW=24, AW=32, NATTR=2)
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_tri_setup_multi;

  localparam int IW      = 24;
  localparam int AW      = 32;
  localparam int NATTR   = 2;
  localparam int DIV_CYC = AW + IW + 12;
  localparam int LAT     = 2 + 2 * NATTR * DIV_CYC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [IW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [NATTR*AW-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic [1:0] cull_mode = 2'd0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [IW:0] A0, A1, A2, B0, B1, B2;
  logic [2*IW:0] C0, C1, C2;
  logic [2*IW+1:0] area;
  logic back_facing;
  logic [NATTR*AW-1:0] grad_x, grad_y;
  logic cull_evt;
  logic [15:0] cull_count;

  int n_chk  = 0;
  int n_fail = 0;
  int lat;

  always #5 clk = ~clk;

  tri_setup_multi #(.IW(IW), .AW(AW), .NATTR(NATTR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .a0(a0), .a1(a1), .a2(a2), .cull_mode(cull_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .A0(A0), .A1(A1), .A2(A2), .B0(B0), .B1(B1), .B2(B2),
    .C0(C0), .C1(C1), .C2(C2), .area(area), .back_facing(back_facing),
    .grad_x(grad_x), .grad_y(grad_y), .cull_evt(cull_evt), .cull_count(cull_count)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers one triangle and returns at the falling edge of the SETUP cycle (T+1).
  task automatic drive(input int px0, input int py0, input int px1, input int py1,
                       input int px2, input int py2,
                       input logic [NATTR*AW-1:0] pa0, input logic [NATTR*AW-1:0] pa1,
                       input logic [NATTR*AW-1:0] pa2, input logic [1:0] pm);
    @(negedge clk);
    x0 = IW'(px0); y0 = IW'(py0); x1 = IW'(px1); y1 = IW'(py1); x2 = IW'(px2); y2 = IW'(py2);
    a0 = pa0; a1 = pa1; a2 = pa2; cull_mode = pm;
    in_valid = 1'b1;
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    lat = 1;
    while (!out_valid && lat < LAT + 50) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, lat, LAT);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("take_in_ready", in_ready, 1);
    chk("take_out_valid", out_valid, 0);
  endtask

  task automatic expect_cull(input string tag, input int cnt);
    chk({tag, "_evt_t1"}, cull_evt, 0);
    @(negedge clk);
    chk({tag, "_evt_t2"}, cull_evt, 1);
    chk({tag, "_ready_t2"}, in_ready, 1);
    chk({tag, "_count"}, cull_count, cnt);
    @(negedge clk);
    chk({tag, "_evt_t3"}, cull_evt, 0);
    for (int i = 0; i < 8; i++) begin
      if (out_valid) chk({tag, "_no_out"}, out_valid, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cull_evt", cull_evt, 0);
    chk("rst_cull_count", cull_count, 0);
    chk("rst_area", area, 0);
    chk("rst_grad_x", grad_x, 0);

    // CCW 16x16 pixel right triangle; attr0 ramps along x, attr1 along y.
    drive(0, 0, 4096, 0, 0, 4096, 64'd0, {32'd0, 32'd1600}, {32'd800, 32'd0}, 2'd0);
    wait_out("ccw_latency");
    chk("ccw_area", area, 16777216);
    chk("ccw_C0", $signed(C0), 16777216);
    chk("ccw_A0", $signed(A0), -4096);
    chk("ccw_B0", $signed(B0), -4096);
    chk("ccw_A1", $signed(A1), 4096);
    chk("ccw_B2", $signed(B2), 4096);
    chk("ccw_bf", back_facing, 0);
    chk("ccw_grad_x", grad_x, {32'd0, 32'd100});
    chk("ccw_grad_y", grad_y, {32'd50, 32'd0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_area", area, 16777216);
      chk("stall_C0", $signed(C0), 16777216);
      chk("stall_grad", {grad_y, grad_x}, {32'd50, 32'd0, 32'd0, 32'd100});
    end
    take();

    // Clockwise (v1/v2 swapped), culled under CULL_NEG.
    drive(0, 0, 0, 4096, 4096, 0, 64'd0, {32'd0, 32'd1600}, {32'd800, 32'd0}, 2'd1);
    expect_cull("cw_m1", 1);

    drive(0, 0, 0, 4096, 4096, 0, 64'd0, {32'd0, 32'd1600}, {32'd800, 32'd0}, 2'd0);
    wait_out("cw_latency");
    chk("cw_bf", back_facing, 1);
    chk("cw_area", area, 16777216);
    chk("cw_A0", $signed(A0), -4096);
    chk("cw_B0", $signed(B0), -4096);
    chk("cw_C0", $signed(C0), 16777216);
    chk("cw_B1", $signed(B1), 4096);
    chk("cw_A2", $signed(A2), 4096);
    chk("cw_grad_x", grad_x, {32'd50, 32'd0});
    chk("cw_grad_y", grad_y, {32'd0, 32'd100});
    take();

    drive(0, 0, 256, 256, 512, 512, 64'd0, 64'd5, 64'd9, 2'd0);
    expect_cull("collinear", 2);

    drive(0, 0, 4096, 0, 0, 4096, 64'd0, 64'd0, 64'd0, 2'd2);
    expect_cull("ccw_m2", 3);

    // Mode 3 behaves as no culling.
    drive(0, 0, 0, 4096, 4096, 0, 64'd0, 64'd0, 64'd0, 2'd3);
    wait_out("m3_latency");
    chk("m3_bf", back_facing, 1);
    take();

    // 25/16 and -25/16 pixel slopes truncate toward zero.
    drive(0, 0, 4096, 0, 0, 4096, 64'd0, {32'hFFFFFFE7, 32'd25}, 64'd0, 2'd0);
    wait_out("trunc_latency");
    chk("trunc_grad_x", grad_x, {32'hFFFFFFFF, 32'd1});
    chk("trunc_grad_y", grad_y, 64'd0);
    take();

    // 1/256 pixel wide triangle with extreme attribute deltas saturates both ways.
    drive(0, 0, 1, 0, 0, 256, 64'd0, {32'h80000000, 32'h7FFFFFFF}, 64'd0, 2'd0);
    wait_out("sat_latency");
    chk("sat_area", area, 256);
    chk("sat_grad_x", grad_x, {32'h80000000, 32'h7FFFFFFF});
    chk("sat_grad_y", grad_y, 64'd0);
    take();

    // Reset in the middle of the divide sequence.
    drive(0, 0, 4096, 0, 0, 4096, 64'd0, {32'd0, 32'd1600}, {32'd800, 32'd0}, 2'd0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cull_count", cull_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < LAT; i++) begin
      if (out_valid || cull_evt) chk("midrst_no_result", {out_valid, cull_evt}, 0);
      @(negedge clk);
    end

    drive(0, 0, 4096, 0, 0, 4096, 64'd0, {32'd0, 32'd1600}, {32'd800, 32'd0}, 2'd0);
    wait_out("post_latency");
    chk("post_area", area, 16777216);
    chk("post_grad_x", grad_x, {32'd0, 32'd100});
    chk("post_grad_y", grad_y, {32'd50, 32'd0});
    take();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
